// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: pipelined carry-lookahead adder/subtractor with
// valid/ready handshakes. The operand is cut into STAGES slices; each stage
// resolves one slice with a GROUP-ary lookahead tree and registers the slice
// carry for the next stage.
// Optional feature macro: PIPELINED_CLA_ADDER_FLAGS_EN enables the registered
// out_overflow / out_zero flags; without it both outputs are tied low.
module pipelined_cla_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int GROUP  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_carry,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_carry,
    output logic             out_overflow,
    output logic             out_zero
);

    // Number of tree levels needed to reduce n leaves to one node with fan-in grp.
    function automatic int tree_levels(input int n, input int grp);
        int cnt;
        int lvl;
        cnt = n;
        lvl = 1;
        while (cnt > 1) begin
            cnt = (cnt + grp - 1) / grp;
            lvl++;
        end
        return lvl;
    endfunction

    localparam int SW     = WIDTH / STAGES;
    localparam int LEVELS = tree_levels(SW, GROUP);

    // Hierarchical lookahead: build group propagate/generate bottom-up, then
    // hand carries down from the slice carry-in. Returns {carry_out, carry into each bit}.
    function automatic logic [SW:0] cla_carries(input logic [SW-1:0] p_bit,
                                                input logic [SW-1:0] g_bit,
                                                input logic          cin);
        logic [SW-1:0] p_l [LEVELS];
        logic [SW-1:0] g_l [LEVELS];
        logic [SW-1:0] c_l [LEVELS];
        int            nodes [LEVELS];
        logic          pg;
        logic          gg;
        logic          run;
        for (int l = 0; l < LEVELS; l++) begin
            p_l[l]   = '0;
            g_l[l]   = '0;
            c_l[l]   = '0;
            nodes[l] = 0;
        end
        p_l[0]   = p_bit;
        g_l[0]   = g_bit;
        nodes[0] = SW;
        for (int l = 1; l < LEVELS; l++) begin
            nodes[l] = (nodes[l-1] + GROUP - 1) / GROUP;
            for (int i = 0; i < SW; i++) begin
                if (i < nodes[l]) begin
                    pg = 1'b1;
                    gg = 1'b0;
                    for (int j = 0; j < GROUP; j++) begin
                        if (i * GROUP + j < nodes[l-1]) begin
                            gg = g_l[l-1][i*GROUP+j] | (p_l[l-1][i*GROUP+j] & gg);
                            pg = pg & p_l[l-1][i*GROUP+j];
                        end
                    end
                    p_l[l][i] = pg;
                    g_l[l][i] = gg;
                end
            end
        end
        c_l[LEVELS-1][0] = cin;
        for (int l = LEVELS - 2; l >= 0; l--) begin
            for (int q = 0; q < SW; q++) begin
                if (q < nodes[l+1]) begin
                    run = c_l[l+1][q];
                    for (int j = 0; j < GROUP; j++) begin
                        if (q * GROUP + j < nodes[l]) begin
                            c_l[l][q*GROUP+j] = run;
                            run = g_l[l][q*GROUP+j] | (p_l[l][q*GROUP+j] & run);
                        end
                    end
                end
            end
        end
        return {g_l[0][SW-1] | (p_l[0][SW-1] & c_l[0][SW-1]), c_l[0]};
    endfunction

    logic [STAGES-1:0] valid_all;
    logic [STAGES:0]   adv;

    // Advance chain: a stage may load when it is empty or the stage after it moves.
    always_comb begin
        adv         = '0;
        adv[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = ~valid_all[k] | adv[k+1];
        end
    end

    assign in_ready = adv[0] | reset;

    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SW;
        localparam int HI = WIDTH - LO;

        logic            v_in;
        logic [HI-1:0]   a_in;
        logic [HI-1:0]   b_in;
        logic            c_in;
        logic [SW:0]     carries;
        logic [SW-1:0]   slice_s;
        logic [LO+SW-1:0] sum_d;
        logic [LO+SW-1:0] sum_q;
        logic            carry_d;
        logic            carry_q;
        logic            valid_q;

        if (k == 0) begin : g_first
            assign v_in  = in_valid;
            assign a_in  = in_a;
            assign b_in  = in_sub ? ~in_b : in_b;
            assign c_in  = in_sub ^ in_carry;
            assign sum_d = slice_s;
        end else begin : g_next
            assign v_in  = g_stage[k-1].valid_q;
            assign a_in  = g_stage[k-1].g_hold.a_q;
            assign b_in  = g_stage[k-1].g_hold.b_q;
            assign c_in  = g_stage[k-1].carry_q;
            assign sum_d = {slice_s, g_stage[k-1].sum_q};
        end

        // Resolve this stage's slice from its carry-in.
        always_comb begin
            carries = cla_carries(a_in[SW-1:0] | b_in[SW-1:0], a_in[SW-1:0] & b_in[SW-1:0], c_in);
            slice_s = a_in[SW-1:0] ^ b_in[SW-1:0] ^ carries[SW-1:0];
            carry_d = carries[SW];
        end

        // Stage register: valid follows the advance; data only captures real ops.
        always_ff @(posedge clock) begin
            if (reset) begin
                valid_q <= 1'b0;
                sum_q   <= '0;
                carry_q <= 1'b0;
            end else if (adv[k]) begin
                valid_q <= v_in;
                if (v_in) begin
                    sum_q   <= sum_d;
                    carry_q <= carry_d;
                end
            end
        end

        assign valid_all[k] = valid_q;

        if (k < STAGES - 1) begin : g_hold
            logic [HI-SW-1:0] a_d;
            logic [HI-SW-1:0] b_d;
            logic [HI-SW-1:0] a_q;
            logic [HI-SW-1:0] b_q;
            assign a_d = a_in[HI-1:SW];
            assign b_d = b_in[HI-1:SW];

            // Carry the still-unprocessed high operand bits to the next stage.
            always_ff @(posedge clock) begin
                if (reset) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv[k] && v_in) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end else begin : g_last
            assign out_valid = valid_q;
            assign out_s     = sum_q;
            assign out_carry = carry_q;
`ifdef PIPELINED_CLA_ADDER_FLAGS_EN
            logic overflow_d;
            logic overflow_q;
            logic zero_d;
            logic zero_q;

            // Signed overflow is the carry into the MSB disagreeing with the carry out.
            always_comb begin
                overflow_d = carries[SW-1] ^ carries[SW];
                zero_d     = (sum_d == '0);
            end

            // Flag registers share the final stage's load condition.
            always_ff @(posedge clock) begin
                if (reset) begin
                    overflow_q <= 1'b0;
                    zero_q     <= 1'b0;
                end else if (adv[k] && v_in) begin
                    overflow_q <= overflow_d;
                    zero_q     <= zero_d;
                end
            end

            assign out_overflow = overflow_q;
            assign out_zero     = zero_q;
`else
            assign out_overflow = 1'b0;
            assign out_zero     = 1'b0;
`endif
        end
    end

endmodule
